// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath sizes and the register file FSM states.
package cpu_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// One register file read port: zero-during-clear, hardwired r0, same-cycle write bypass.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int BITS = XLEN,
  parameter int AW   = 5
) (
  input  logic            i_clear,
  input  logic [AW-1:0]   i_ra,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [BITS-1:0] i_wd,
  input  logic [BITS-1:0] i_mem_rd,
  output logic [BITS-1:0] o_rd
);

  // Priority: clearing/reset, then r0, then bypass of the in-flight write, then storage.
  always_comb begin
    o_rd = i_mem_rd;
    if (i_clear)                       o_rd = '0;
    else if (i_ra == '0)               o_rd = '0;
    else if (i_we && (i_wa == i_ra))   o_rd = i_wd;
  end

endmodule

// File: rtl/regfile.sv
// 2R/1W architectural register file with a one-register-per-cycle clear sequencer after reset.
module regfile
  import cpu_pkg::*;
#(
  parameter int bits = XLEN,
  parameter int regs = NREGS,
  localparam int aw  = $clog2(regs)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [aw-1:0]   ra1,
  input  logic [aw-1:0]   ra2,
  output logic [bits-1:0] rd1,
  output logic [bits-1:0] rd2,
  input  logic            we,
  input  logic [aw-1:0]   wa,
  input  logic [bits-1:0] wd,
  output logic            busy
);

  rf_state_t         r_state;
  logic [aw-1:0]     r_cnt;
  logic [bits-1:0]   r_mem [regs];

  logic              w_clearing;
  logic              w_rd_clear;
  logic [bits-1:0]   w_mem_rd1;
  logic [bits-1:0]   w_mem_rd2;

  assign w_clearing = (r_state == RF_CLEAR);
  assign w_rd_clear = reset | w_clearing;
  assign busy       = w_clearing;
  assign w_mem_rd1  = r_mem[ra1];
  assign w_mem_rd2  = r_mem[ra2];

  // Clear sequencer: reset always restarts at index 0; walk up to the last register, then go ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == RF_CLEAR) begin
      if (r_cnt == aw'(regs - 1)) r_state <= RF_READY;
      else                        r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Storage: zero the pointed register while clearing, otherwise accept non-r0 writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clearing)                r_mem[r_cnt] <= '0;
      else if (we && (wa != '0))     r_mem[wa]    <= wd;
    end
  end

  rf_read_port #(.BITS(bits), .AW(aw)) u_rp1 (
    .i_clear  (w_rd_clear),
    .i_ra     (ra1),
    .i_we     (we),
    .i_wa     (wa),
    .i_wd     (wd),
    .i_mem_rd (w_mem_rd1),
    .o_rd     (rd1)
  );

  rf_read_port #(.BITS(bits), .AW(aw)) u_rp2 (
    .i_clear  (w_rd_clear),
    .i_ra     (ra2),
    .i_we     (we),
    .i_wa     (wa),
    .i_wd     (wd),
    .i_mem_rd (w_mem_rd2),
    .o_rd     (rd2)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, corner sequences, random vs. model.
module tb_regfile;
  import cpu_pkg::*;

  localparam int BITS = 32;
  localparam int REGS = 32;
  localparam int AW   = 5;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic            we    = 1'b0;
  logic [AW-1:0]   ra1   = '0;
  logic [AW-1:0]   ra2   = '0;
  logic [AW-1:0]   wa    = '0;
  logic [BITS-1:0] wd    = '0;
  logic [BITS-1:0] rd1, rd2;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain array of contents plus number of clear edges still owed.
  logic [BITS-1:0] m_mem [REGS];
  int              m_left = REGS;

  regfile #(.bits(BITS), .regs(REGS)) dut (
    .clk   (clk),
    .reset (reset),
    .ra1   (ra1),
    .ra2   (ra2),
    .rd1   (rd1),
    .rd2   (rd2),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [BITS-1:0] m_read(input logic [AW-1:0] ra);
    if (reset || m_left > 0) return '0;
    if (ra == 0)             return '0;
    if (we && wa == ra)      return wd;
    return m_mem[ra];
  endfunction

  task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one edge, updating the model from the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_left = REGS;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_left > 0) begin
      m_left--;
    end else if (we && wa != 0) begin
      m_mem[wa] = wd;
    end
    #1;
  endtask

  task automatic check_ports(input string tag);
    chk({tag, "_rd1"}, rd1, m_read(ra1));
    chk({tag, "_rd2"}, rd2, m_read(ra2));
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (m_left > 0)});
  endtask

  // Count edges until busy drops (bounded), expecting exactly REGS.
  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_busy_edges"}, n, REGS);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < REGS; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(REGS - 1 - i);
      #1;
      chk($sformatf("%s_r%0d_p1", tag, i), rd1, '0);
      chk($sformatf("%s_r%0d_p2", tag, REGS - 1 - i), rd2, '0);
    end
  endtask

  typedef struct {
    logic            we;
    logic [AW-1:0]   wa;
    logic [BITS-1:0] wd;
    logic [AW-1:0]   ra1;
    logic [AW-1:0]   ra2;
    logic [BITS-1:0] e1;
    logic [BITS-1:0] e2;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd7, 32'h12,       5'd5, 5'd7, 32'hDEADBEEF, 32'h12};
    tbl[2] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 32'hDEADBEEF, 32'h12};
    tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 32'h0,        32'h12};
    tbl[5] = '{1'b1, 5'd3, 32'hA5A5,     5'd3, 5'd3, 32'hA5A5,     32'hA5A5};
    tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd5, 32'hA5A5,     32'hDEADBEEF};
    tbl[7] = '{1'b1, 5'd5, 32'h1,        5'd5, 5'd31, 32'h1,       32'h0};
    tbl[8] = '{1'b0, 5'd31, 32'h77,      5'd5, 5'd31, 32'h1,       32'h0};

    // Initial reset: two edges, outputs forced to zero while held.
    reset = 1'b1; ra1 = 5'd5; ra2 = 5'd9;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_rd1", rd1, '0);
    chk("rst_rd2", rd2, '0);
    reset = 1'b0;
    #1;
    wait_clear("init");
    chk("init_ready_busy", {31'd0, busy}, 32'd0);
    read_all_zero("init");

    // Directed vectors; model tracks every edge so later phases stay in sync.
    for (int i = 0; i < 9; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), rd1, tbl[i].e1);
      chk($sformatf("vec%0d_rd2", i), rd2, tbl[i].e2);
      tick();
    end
    we = 1'b0;

    // Writes presented during the clear must be dropped, and not bypassed.
    reset = 1'b1; tick(); reset = 1'b0;
    we = 1'b1; wa = 5'd4; wd = 32'h55; ra1 = 5'd4; ra2 = 5'd4;
    #1;
    chk("wbusy_rd1_during", rd1, '0);
    chk("wbusy_rd2_during", rd2, '0);
    wait_clear("wbusy");
    we = 1'b0;
    #1;
    chk("wbusy_after_rd1", rd1, '0);

    // Fill every register, then reset mid-clear at cnt=10.
    we = 1'b1;
    for (int i = 1; i < REGS; i++) begin
      wa = AW'(i); wd = 32'h1111 * i;
      tick();
    end
    we = 1'b0; ra1 = 5'd20; ra2 = 5'd2;
    #1;
    chk("fill_rd1", rd1, 32'h1111 * 20);
    chk("fill_rd2", rd2, 32'h2222);
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (10) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    wait_clear("mid");
    read_all_zero("mid");

    // Reset from READY: reads go to zero combinationally, busy only after the edge.
    we = 1'b1; wa = 5'd9; wd = 32'h99; tick();
    we = 1'b0; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    chk("x9_rd1", rd1, 32'h99);
    reset = 1'b1;
    #1;
    chk("rrdy_rd1_now", rd1, '0);
    chk("rrdy_rd2_now", rd2, '0);
    chk("rrdy_busy_pre", {31'd0, busy}, 32'd0);
    tick();
    chk("rrdy_busy_post", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    wait_clear("rrdy");
    ra1 = 5'd9;
    #1;
    chk("rrdy_x9_zero", rd1, '0);

    // Random traffic against the model, with rare resets.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      we    = $urandom_range(0, 1);
      wa    = AW'($urandom_range(0, REGS - 1));
      wd    = $urandom;
      ra1   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, REGS - 1));
      ra2   = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, REGS - 1));
      #1;
      check_ports($sformatf("rnd%0d", c));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
